fb_arbiter: RTL and testbench

- Shares the single-port 4096x8 synchronous framebuffer RAM between two requesters: the VGA scanout fetcher (video) and the CPU bus port.
- Grants at most one RAM access per clk50 cycle. Video has priority. A starvation counter guarantees the CPU a slot.
- Returns read data through a fixed-latency pipeline.
- Sits between the CPU bus, the line fetcher of vga_controller, and the framebuffer RAM macro.

---
 rtl/fb_arbiter.sv | 109 ++++++++++
 tb/tb_fb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: video scanout has priority, the CPU is guaranteed a slot by a
// starvation counter. Read data returns through a fixed two-stage tag pipeline.
module fb_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic              clk50,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {CIdle, CRd, CWr} cpu_st_e;

   localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

   cpu_st_e    st_q, st_d;
   logic [7:0] cnt_q;
   // {valid, is_video} for reads in flight; stage 1 lines up with ram_rdata
   logic [1:0] tag0_q, tag1_q;
   logic       cpu_elig, starve, vid_acc, cpu_acc, vid_rd_ret, cpu_rd_ret;

   assign cpu_elig   = cpu_req && (st_q == CIdle) && !cpu_ack;
   assign starve     = (cnt_q >= Limit);
   assign vid_acc    = vid_req && !(cpu_elig && starve);
   assign cpu_acc    = !vid_acc && cpu_elig;
   assign vid_gnt    = vid_acc;
   assign vid_rd_ret = tag1_q[1] && tag1_q[0];
   assign cpu_rd_ret = tag1_q[1] && !tag1_q[0];

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         st_q <= CIdle;
      end else begin
         st_q <= st_d;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         CIdle:   if (cpu_acc) st_d = cpu_we ? CWr : CRd;
         CRd:     if (cpu_rd_ret) st_d = CIdle;
         CWr:     st_d = CIdle;
         default: st_d = CIdle;
      endcase
   end

   always_comb begin
      cpu_busy = (st_q != CIdle);
   end

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         tag0_q    <= '0;
         tag1_q    <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         vid_valid <= 1'b0;
         vid_data  <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         if (cpu_acc) begin
            cnt_q <= '0;
         end else if (cpu_elig && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
         end
         tag0_q <= {vid_acc || (cpu_acc && !cpu_we), vid_acc};
         tag1_q <= tag0_q;
         ram_we <= cpu_acc && cpu_we;
         if (vid_acc) begin
            ram_addr <= vid_addr;
         end else if (cpu_acc) begin
            ram_addr <= cpu_addr;
         end
         if (vid_acc || cpu_acc) begin
            ram_wdata <= cpu_wdata;
         end
         vid_valid <= vid_rd_ret;
         if (vid_rd_ret) begin
            vid_data <= ram_rdata;
         end
         // write acks one cycle after issue, read acks when its data returns
         cpu_ack <= cpu_rd_ret || (st_q == CWr);
         if (cpu_rd_ret) begin
            cpu_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: RAM behavioural model plus a transaction-level reference that
// predicts grants, completion cycles and returned data from the arbitration rules.
module tb_fb_arbiter;

   localparam int Limit = 16;

   logic        clk50 = 1'b0;
   logic        rst   = 1'b1;
   logic        vid_req = 1'b0;
   logic [11:0] vid_addr = '0;
   logic        vid_gnt, vid_valid;
   logic [7:0]  vid_data;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack, cpu_busy;
   logic [7:0]  cpu_rdata;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata, ram_rdata;

   fb_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(Limit)) dut (
      .clk50(clk50), .rst(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_valid(vid_valid), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #10 clk50 = ~clk50;

   // Synchronous RAM: address registered, data available the following cycle.
   logic [7:0]  ram_mem [4096];
   logic [11:0] ram_rd_addr = '0;
   always @(posedge clk50) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rd_addr <= ram_addr;
   end
   assign ram_rdata = ram_mem[ram_rd_addr];

   // Reference model state
   logic [7:0]  ref_mem [4096];
   int          checks = 0, failures = 0;
   int          cyc = 0, cnt_m = 0, acc_cyc = -10, ack_cyc = -10, we_cnt = 0;
   logic        s_vv [8], s_ack [8], s_rdv [8];
   logic [7:0]  s_vd [8], s_rd [8];
   logic [7:0]  exp_vid_data, exp_cpu_rdata, pend_wdata;
   logic [11:0] exp_ram_addr, pend_addr;
   logic        pend_acc, pend_we;
   logic        dut_ack, dut_vgnt, dut_vv;
   logic [7:0]  dut_vd, dut_crd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic reset_check();
      check("rst_vid_valid", vid_valid, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_cpu_busy", cpu_busy, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_vid_data", vid_data, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         s_vv[i] = 0; s_ack[i] = 0; s_rdv[i] = 0; s_vd[i] = '0; s_rd[i] = '0;
      end
      cnt_m = 0; acc_cyc = cyc - 10; ack_cyc = cyc - 10;
      exp_vid_data = '0; exp_cpu_rdata = '0; exp_ram_addr = '0;
      pend_acc = 0; pend_we = 0; pend_addr = '0; pend_wdata = '0;
      dut_ack = 0; dut_vgnt = 0; dut_vv = 0; dut_vd = '0; dut_crd = '0;
   endtask

   // Called at a falling edge with this cycle's inputs driven; returns at the next one.
   task automatic tick();
      int  k;
      logic elig, vwin, cwin;
      #1;
      k = cyc % 8;
      if (s_vv[k]) exp_vid_data = s_vd[k];
      if (s_ack[k] && s_rdv[k]) exp_cpu_rdata = s_rd[k];
      if (pend_acc) exp_ram_addr = pend_addr;
      dut_ack = cpu_ack; dut_vgnt = vid_gnt; dut_vv = vid_valid;
      dut_vd = vid_data; dut_crd = cpu_rdata;
      if (ram_we) we_cnt++;
      check("vid_valid", vid_valid, s_vv[k]);
      check("vid_data", vid_data, exp_vid_data);
      check("cpu_ack", cpu_ack, s_ack[k]);
      check("cpu_rdata", cpu_rdata, exp_cpu_rdata);
      check("cpu_busy", cpu_busy, (cyc > acc_cyc) && (cyc < ack_cyc));
      check("ram_we", ram_we, pend_we);
      check("ram_addr", ram_addr, exp_ram_addr);
      if (pend_we) check("ram_wdata", ram_wdata, pend_wdata);
      // Arbitration for this cycle, completion scheduled by the fixed latencies
      elig = cpu_req && !((cyc > acc_cyc) && (cyc <= ack_cyc));
      vwin = vid_req && !(elig && (cnt_m >= Limit));
      cwin = !vwin && elig;
      pend_acc = vwin || cwin;
      pend_we = cwin && cpu_we;
      pend_wdata = cpu_wdata;
      if (vwin) begin
         pend_addr = vid_addr;
         s_vv[(cyc + 3) % 8] = 1;
         s_vd[(cyc + 3) % 8] = ref_mem[vid_addr];
      end else if (cwin) begin
         pend_addr = cpu_addr;
         acc_cyc = cyc;
         if (cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            ack_cyc = cyc + 2;
         end else begin
            ack_cyc = cyc + 3;
            s_rdv[(cyc + 3) % 8] = 1;
            s_rd[(cyc + 3) % 8] = ref_mem[cpu_addr];
         end
         s_ack[ack_cyc % 8] = 1;
      end
      if (cwin) cnt_m = 0;
      else if (elig && cnt_m < 255) cnt_m++;
      check("vid_gnt", vid_gnt, vwin);
      s_vv[k] = 0; s_ack[k] = 0; s_rdv[k] = 0;
      cyc++;
      @(negedge clk50);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      #1 reset_check();
      repeat (n) @(negedge clk50);
      reset_check();
      rst = 1'b0;
      model_clear();
   endtask

   task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] d,
                             output int lat);
      int n = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      do begin
         tick();
         n++;
      end while (!dut_ack && n < 60);
      if (!dut_ack) check("cpu_ack_timeout", dut_ack, 1);
      lat = n - 1;
      cpu_req = 1'b0;
   endtask

   initial begin
      int g, lat;
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      do_reset(3);

      // Video stream: address advances on each grant
      vid_req = 1'b1; vid_addr = '0; g = 0;
      for (int i = 0; i < 40 && g < 16; i++) begin
         tick();
         if (dut_vgnt) begin
            g++;
            vid_addr = vid_addr + 12'd1;
         end
      end
      check("vid_stream_grants", g, 16);
      vid_req = 1'b0;
      tick();
      // Reset with reads still in flight, then idle
      do_reset(2);
      we_cnt = 0;
      repeat (20) tick();
      check("idle_ram_we_count", we_cnt, 0);

      // CPU write then read
      we_cnt = 0;
      cpu_access(1'b1, 12'h123, 8'hA7, lat);
      check("wr_ack_latency", lat, 2);
      repeat (2) tick();
      check("wr_ram_we_cycles", we_cnt, 1);
      cpu_access(1'b0, 12'h123, 8'h00, lat);
      check("rd_ack_latency", lat, 3);
      check("rd_data", dut_crd, 8'hA7);
      tick();

      // Read-after-write: video reads the address the cycle after the CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h7FF; cpu_wdata = 8'h3C;
      tick();
      vid_req = 1'b1; vid_addr = 12'h7FF;
      tick();
      vid_req = 1'b0;
      tick();
      cpu_req = 1'b0;
      repeat (2) tick();
      check("raw_vid_valid", dut_vv, 1);
      check("raw_vid_data", dut_vd, 8'h3C);

      // Collision: continuous video against a CPU request
      vid_req = 1'b1; vid_addr = 12'h040;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h11;
      g = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!dut_vgnt) break;
         g++;
      end
      check("starve_vid_grants", g, 16);
      tick();
      check("vid_resume", dut_vgnt, 1);
      repeat (60) tick();
      for (int i = 0; i < 40 && !dut_ack; i++) tick();
      cpu_req = 1'b0; vid_req = 1'b0;
      repeat (4) tick();

      // Reset one cycle after a CPU read accept; held request is re-accepted
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
      tick();
      do_reset(2);
      cpu_access(1'b0, 12'h123, 8'h00, lat);
      check("rearm_rd_latency", lat, 3);
      check("rearm_rd_data", dut_crd, 8'hA7);
      tick();

      // Random traffic over a small address window to provoke hazards and starvation
      for (int i = 0; i < 1200; i++) begin
         vid_req  = (i < 600) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) != 0);
         vid_addr = 12'($urandom_range(0, 15));
         if (cpu_req && dut_ack) begin
            cpu_req = 1'b0;
         end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = $urandom_range(0, 1) != 0;
            cpu_addr  = 12'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
         end
         tick();
      end
      vid_req = 1'b0;
      for (int i = 0; i < 40 && cpu_req && !dut_ack; i++) tick();
      cpu_req = 1'b0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
